// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: radix-4 Booth MUL, non-restoring signed DIV, 1-cycle ops.
// Optional macro ALU_DIVZERO_EN adds a div_zero flag and a fast divide-by-zero path.
module alu_seq_muldiv #(
  parameter int          WIDTH = 32,
  parameter logic [7:0]  CCODE = 8'hCC
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef ALU_DIVZERO_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ILL = WIDTH'({(WIDTH + 7) / 8{CCODE}});
  localparam logic [WIDTH-1:0] WV  = WIDTH'(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    IDLE, MUL_ITER, DIV_ITER, DIV_FIX, DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, m, term, acc_n;
  logic [WIDTH:0]     mq;
  logic [WIDTH:0]     r, r_sh, r_new, r_fix;
  logic [WIDTH-1:0]   q, d, q_new;
  logic               sq, sr;
  logic [WIDTH-1:0]   res, rot, rinv, a_abs, b_abs;
  logic               accept, dz_hit;

  assign accept = start && (state == IDLE || state == DONE);
  assign a_abs  = a[WIDTH-1] ? -a : a;
  assign b_abs  = b[WIDTH-1] ? -b : b;

`ifdef ALU_DIVZERO_EN
  logic dz_r;
  assign dz_hit   = (opcode == OP_DIV) && (b == '0);
  assign div_zero = dz_r && done;
`else
  assign dz_hit = 1'b0;
`endif

  // single-cycle result for the non-iterative opcodes
  always_comb begin
    rot  = b % WV;
    rinv = WV - rot;
    res  = ILL;
    case (opcode)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SHR:  res = a >> b;
      OP_SHRA: res = $signed(a) >>> b;
      OP_SHL:  res = a << b;
      OP_ROR:  res = (a >> rot) | (a << rinv);
      OP_ROL:  res = (a << rot) | (a >> rinv);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NEG:  res = -b;
      OP_NOT:  res = ~b;
      default: res = ILL;
    endcase
  end

  // Booth digit from the low three bits of the shifting multiplier
  always_comb begin
    term = '0;
    case (mq[2:0])
      3'b001, 3'b010: term = m;
      3'b011:         term = m << 1;
      3'b100:         term = -(m << 1);
      3'b101, 3'b110: term = -m;
      default:        term = '0;
    endcase
    acc_n = acc + term;
  end

  // one non-restoring step plus the final remainder correction
  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    r_new = r[WIDTH] ? r_sh + {1'b0, d} : r_sh - {1'b0, d};
    q_new = {q[WIDTH-2:0], ~r_new[WIDTH]};
    r_fix = r[WIDTH] ? r + {1'b0, d} : r;
  end

  // state register
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= nxt;
  end

  // next state and status outputs
  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        nxt  = IDLE;
        if (accept) begin
          if (opcode == OP_MUL)                 nxt = MUL_ITER;
          else if (opcode == OP_DIV && !dz_hit) nxt = DIV_ITER;
          else                                  nxt = DONE;
        end
      end
      MUL_ITER: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH / 2 - 1)) nxt = DONE;
      end
      DIV_ITER: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) nxt = DIV_FIX;
      end
      DIV_FIX: begin
        busy = 1'b1;
        nxt  = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  // operand latches, iteration registers and result registers
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= '0;
      acc <= '0;
      m   <= '0;
      mq  <= '0;
      r   <= '0;
      q   <= '0;
      d   <= '0;
      sq  <= 1'b0;
      sr  <= 1'b0;
      hi  <= '0;
      lo  <= '0;
`ifdef ALU_DIVZERO_EN
      dz_r <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
`ifdef ALU_DIVZERO_EN
      dz_r <= dz_hit;
`endif
      if (opcode == OP_MUL) begin
        acc <= '0;
        m   <= {{WIDTH{a[WIDTH-1]}}, a};
        mq  <= {b, 1'b0};
      end else if (opcode == OP_DIV) begin
        r  <= '0;
        q  <= a_abs;
        d  <= b_abs;
        sq <= a[WIDTH-1] ^ b[WIDTH-1];
        sr <= a[WIDTH-1];
        if (dz_hit) begin
          hi <= a;
          lo <= '1;
        end
      end else begin
        hi <= '0;
        lo <= res;
      end
    end else begin
      case (state)
        MUL_ITER: begin
          acc <= acc_n;
          m   <= m << 2;
          mq  <= mq >> 2;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH / 2 - 1)) {hi, lo} <= acc_n;
        end
        DIV_ITER: begin
          r   <= r_new;
          q   <= q_new;
          cnt <= cnt + 1'b1;
        end
        DIV_FIX: begin
          r  <= r_fix;
          hi <= sr ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
          lo <= sq ? -q : q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at WIDTH=32.
// Covers latency, results, handshake, clear abort and the optional div-by-zero path.
module tb_alu_seq_muldiv;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [4:0]  opcode;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
`ifdef ALU_DIVZERO_EN
  logic        div_zero;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int lat;
  int seen;

  alu_seq_muldiv dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
`ifdef ALU_DIVZERO_EN
    .div_zero(div_zero),
`endif
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // caller is at a negedge; request is accepted at the next posedge
  task automatic launch(input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y);
    opcode = op;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    a      = 32'hDEAD_BEEF;
    b      = 32'h0BAD_F00D;
    t0     = cyc;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (done) begin
        l = cyc - t0 + 1;
        break;
      end
    end
    if (l < 0) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic one(input string tag, input logic [4:0] op,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp);
    int l;
    launch(op, x, y);
    wait_done(l);
    chk({tag, "_lat"}, l, 1);
    chk({tag, "_lo"}, lo, exp);
    chk({tag, "_hi"}, hi, 0);
  endtask

  initial begin
    clear  = 1'b1;
    start  = 1'b0;
    opcode = '0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    clear = 1'b0;

    launch(5'b01111, 32'hFFFF_FFF9, 32'd3);
    wait_done(lat);
    chk("mul1_lat", lat, 17);
    chk("mul1_hi", hi, 32'hFFFF_FFFF);
    chk("mul1_lo", lo, 32'hFFFF_FFEB);

    one("add", 5'b00011, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    one("sub", 5'b00100, 32'd5, 32'd7, 32'hFFFF_FFFE);
    one("and", 5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    one("or",  5'b01011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    one("neg", 5'b10001, 32'd9, 32'd1, 32'hFFFF_FFFF);
    one("not", 5'b10010, 32'd9, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    one("shl", 5'b00111, 32'd1, 32'd4, 32'd16);
    one("shr32", 5'b00101, 32'h8000_0000, 32'd32, 32'd0);
    one("shr31", 5'b00101, 32'h8000_0000, 32'd31, 32'd1);
    one("shra40", 5'b00110, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF);
    one("shra4", 5'b00110, 32'h8000_0000, 32'd4, 32'hF800_0000);
    one("ror33", 5'b01000, 32'd1, 32'd33, 32'h8000_0000);
    one("ror4", 5'b01000, 32'h1234_5678, 32'd4, 32'h8123_4567);
    one("rol1", 5'b01001, 32'h8000_0000, 32'd1, 32'd1);
    one("rol0", 5'b01001, 32'h1234_5678, 32'd0, 32'h1234_5678);
    one("ill", 5'b11111, 32'd1, 32'd2, 32'hCCCC_CCCC);

    launch(5'b01111, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    chk("mul2_hi", hi, 32'h4000_0000);
    chk("mul2_lo", lo, 0);

    launch(5'b10000, 32'hFFFF_FFEF, 32'd5);
    wait_done(lat);
    chk("div1_lat", lat, 34);
    chk("div1_lo", lo, 32'hFFFF_FFFD);
    chk("div1_hi", hi, 32'hFFFF_FFFE);

    launch(5'b10000, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    chk("mid_busy", busy, 1);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_hi", hi, 0);
    chk("clr_lo", lo, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("clr_nodone", seen, 0);

    launch(5'b01111, 32'd1234, 32'hFFFF_FFFE);
    wait_done(lat);
    chk("mul3_lat", lat, 17);
    chk("mul3_hi", hi, 32'hFFFF_FFFF);
    chk("mul3_lo", lo, 32'hFFFF_F65C);

    launch(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 0);

    launch(5'b10000, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    opcode = 5'b01111;
    a      = 32'd3;
    b      = 32'd3;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat, 34);
    chk("ign_lo", lo, 14);
    chk("ign_hi", hi, 2);

    launch(5'b00011, 32'd2, 32'd3);
    wait_done(lat);
    chk("b2b_lat", lat, 1);
    chk("b2b_lo", lo, 5);
    chk("b2b_hi", hi, 0);
    @(negedge clock);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_lo", lo, 5);

`ifdef ALU_DIVZERO_EN
    launch(5'b10000, 32'd42, 32'd0);
    wait_done(lat);
    chk("dz_lat", lat, 1);
    chk("dz_hi", hi, 42);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_flag", div_zero, 1);
    launch(5'b00011, 32'd1, 32'd1);
    wait_done(lat);
    chk("dz_clr", div_zero, 0);
    chk("dz_add", lo, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised multi-cycle successor to the phase-1 combinational ALU.
- Executes the 13 CPU-documented ALU opcodes with a start/done handshake.
- MUL uses radix-4 Booth (bit-pair recoding), one recoded digit per cycle.
- DIV uses signed non-restoring division, one quotient bit per cycle.
- All other ops complete in one cycle. Sits between the register-file A/B operand latches and the HI/LO/Z registers of the datapath.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4.
- CCODE, 8'hCC, byte replicated across lo for an illegal opcode.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when idle.
- opcode  in  5  operation code: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- a  in  WIDTH  operand A (multiplicand / dividend / shift source).
- b  in  WIDTH  operand B (multiplier / divisor / shift amount / NEG-NOT source).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  MUL upper product / DIV remainder / 0 otherwise.
- lo  out  WIDTH  MUL lower product / DIV quotient / result.

Behaviour:
- Reset: synchronous, active-high. While clear is high at a rising edge: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers 0. Clear has priority over start and aborts any in-flight op; no done is produced for an aborted op.
- States: IDLE, MUL_ITER, DIV_ITER, DIV_FIX, DONE.
- Accepting a request:
  - start is accepted only in IDLE or DONE. a, b and opcode are latched at the accepting edge, so inputs may change afterwards.
  - start in any other state is ignored; it is neither queued nor an error.
- Single-cycle ops: the accepting edge goes IDLE/DONE -> DONE with result in lo and hi=0. done is high the cycle after start (latency 1).
- Single-cycle op results:
  - ADD/SUB: a+b and a-b, modulo 2^WIDTH.
  - AND/OR: bitwise.
  - NEG: -b (two's complement).
  - NOT: ~b.
  - SHL/SHR: logical shift of a by unsigned b; b >= WIDTH gives 0.
  - SHRA: arithmetic shift of a; b >= WIDTH gives all copies of a[WIDTH-1].
  - ROR/ROL: rotate a by b mod WIDTH; amount 0 returns a unchanged.
  - Illegal opcode: lo = CCODE replicated, hi=0, done still pulses.
- MUL (signed x signed, 2*WIDTH product):
  - Recoding: digit i uses b bits {2i+1, 2i, 2i-1}, with b[-1]=0. Digit values are 0, ±M, ±2M, with M = a sign-extended to 2*WIDTH.
  - Each MUL_ITER cycle adds digit*M << 2i to the accumulator.
  - Counter runs 0..WIDTH/2-1, then the state goes to DONE.
  - Latency WIDTH/2+1 (17 at WIDTH=32). {hi,lo} = full product.
- DIV (signed, truncating toward zero):
  - At accept: latch |a| and |b|, plus the sign of a and the sign of a XOR b.
  - DIV_ITER runs WIDTH cycles of non-restoring division: shift {R,Q} left; R = R-D if R >= 0, else R+D; Q[0] = ~R[msb]. R is WIDTH+1 bits.
  - DIV_FIX (1 cycle): if R < 0, R += D. Then negate Q if the signs differed, and negate R if a was negative.
  - Latency WIDTH+2 (34 at WIDTH=32). hi = remainder (sign of dividend), lo = quotient.
  - Most-negative / -1: quotient wraps to the most-negative value, remainder 0.
  - Divide by zero without the optional feature: full latency, hi/lo values not specified.
- busy: high in MUL_ITER, DIV_ITER and DIV_FIX; low in IDLE and DONE.
- done: high only in DONE. DONE -> IDLE next cycle unless start is accepted (back-to-back allowed).
- Result hold: hi/lo hold their value until the next accepted start completes or until clear.

Optional Feature:
- Macro ALU_DIVZERO_EN.
- Defined:
  - Adds output div_zero (1 bit), reset 0.
  - DIV with b==0 skips the iterations: DONE on the edge after accept (latency 1), hi=a, lo = all ones, div_zero=1 for that done cycle.
  - div_zero is 0 on every other done.
- Undefined: no div_zero port; b==0 runs the full divide with unspecified result.

Test Plan:
- MUL a=-7 (0xFFFFFFF9), b=3 -> done 17 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-17, b=5 -> done 34 cycles after start; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). Also a=100, b=7 -> lo=14, hi=2.
- Shifts/rotates: SHRA 0x80000000 by 40 -> 0xFFFFFFFF; SHR by 32 -> 0; ROR 0x00000001 by 33 -> 0x80000000; ROL 0x80000000 by 1 -> 0x00000001. Each with done at latency 1 and hi=0.
- Handshake: start DIV, re-assert start with MUL at cycle 5 -> ignored, DIV result unchanged. Back-to-back ADD 2+3 issued in the DONE cycle -> lo=5 one cycle later.
- Clear asserted at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows. A new MUL then completes correctly.
- Opcode 11111 -> lo=0xCCCCCCCC, hi=0. With ALU_DIVZERO_EN: DIV 42/0 -> latency 1, hi=42, lo=0xFFFFFFFF, div_zero=1.
